// File: rtl/if_id_skid_reg_if.sv
// IF->ID handshake bundle: fetch-side valid/ready with PC/instruction, and
// decode-side valid/ready with the pre-decoded main entry.
// slave  = the pipeline register itself
// master = the environment driving fetch and consuming decode
interface if_id_skid_if #(
  parameter int DW = 32
);
  // fetch side
  logic          if_valid;
  logic          if_ready;
  logic [DW-1:0] if_pc;
  logic [DW-1:0] if_inst;
  // decode side
  logic          id_valid;
  logic          id_ready;
  logic [DW-1:0] id_pc;
  logic [DW-1:0] id_inst;
  logic [2:0]    id_imm_sel;
  logic          id_illegal;

  modport slave (
    input  if_valid, if_pc, if_inst, id_ready,
    output if_ready, id_valid, id_pc, id_inst, id_imm_sel, id_illegal
  );

  modport master (
    output if_valid, if_pc, if_inst, id_ready,
    input  if_ready, id_valid, id_pc, id_inst, id_imm_sel, id_illegal
  );
endinterface

// File: rtl/if_id_skid_reg.sv
// IF->ID pipeline register with a 2-entry skid buffer.
// The main entry drives decode; the skid entry absorbs one extra fetch while
// decode stalls, so if_ready can be a pure register (no id_ready -> if_ready
// path). Each entry carries its opcode pre-decode (imm select + illegal flag),
// computed once when the instruction is loaded from fetch.
module if_id_skid_reg #(
  parameter int            DW       = 32,
  parameter logic [DW-1:0] NOP_INST = DW'(32'h0000_0013)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  if_id_skid_if.slave      bus
);

  // Occupancy encoded as {main_valid, skid_valid}; {0,1} cannot occur.
  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ONE   = 2'b10;
  localparam logic [1:0] ST_FULL  = 2'b11;

  // RV32 base opcodes recognised by the pre-decoder
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  // imm_generator select codes
  localparam logic [2:0] IMM_I   = 3'b000;
  localparam logic [2:0] IMM_S   = 3'b001;
  localparam logic [2:0] IMM_B   = 3'b010;
  localparam logic [2:0] IMM_J   = 3'b011;
  localparam logic [2:0] IMM_U   = 3'b100;
  localparam logic [2:0] IMM_CSR = 3'b101;

  logic [1:0]    state_q, state_d;

  logic [DW-1:0] main_pc_q,   main_pc_d;
  logic [DW-1:0] main_inst_q, main_inst_d;
  logic [2:0]    main_sel_q,  main_sel_d;
  logic          main_ill_q,  main_ill_d;

  logic [DW-1:0] skid_pc_q,   skid_pc_d;
  logic [DW-1:0] skid_inst_q, skid_inst_d;
  logic [2:0]    skid_sel_q,  skid_sel_d;
  logic          skid_ill_q,  skid_ill_d;

  logic          main_valid;
  logic          skid_valid;
  logic          accept;
  logic          consume;
  logic          load_main_from_in;
  logic          load_main_from_skid;
  logic          load_skid_from_in;
  logic [2:0]    in_sel;
  logic          in_ill;

  assign main_valid = state_q[1];
  assign skid_valid = state_q[0];
  assign accept     = bus.if_valid & bus.if_ready;
  assign consume    = main_valid & bus.id_ready;

  // Every output below depends only on registers, never on the *_valid/ready inputs.
  assign bus.if_ready   = ~skid_valid;
  assign bus.id_valid   = main_valid;
  assign bus.id_pc      = main_pc_q;
  assign bus.id_inst    = main_valid ? main_inst_q : NOP_INST;
  assign bus.id_imm_sel = main_sel_q;
  assign bus.id_illegal = main_ill_q;

  // Pre-decode the incoming opcode into {illegal, imm_sel}
  always_comb begin
    in_sel = IMM_I;
    in_ill = 1'b0;
    unique case (bus.if_inst[6:0])
      OP_LOAD, OP_IMM, OP_JALR: in_sel = IMM_I;
      OP_STORE:                 in_sel = IMM_S;
      OP_BRANCH:                in_sel = IMM_B;
      OP_JAL:                   in_sel = IMM_J;
      OP_LUI, OP_AUIPC:         in_sel = IMM_U;
      OP_SYSTEM:                in_sel = IMM_CSR;
      OP_REG:                   in_sel = IMM_I;   // R-type: immediate unused
      default:                  in_ill = 1'b1;
    endcase
  end

  // Occupancy transitions; flush overrides any simultaneous accept/consume
  always_comb begin
    state_d             = state_q;
    load_main_from_in   = 1'b0;
    load_main_from_skid = 1'b0;
    load_skid_from_in   = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            load_main_from_in = 1'b1;
            state_d           = ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && consume) begin
            load_main_from_in = 1'b1;
          end else if (accept) begin
            load_skid_from_in = 1'b1;
            state_d           = ST_FULL;
          end else if (consume) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          // if_ready is low here, so only a consume can change anything
          if (consume) begin
            load_main_from_skid = 1'b1;
            state_d             = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // Main entry payload: load from fetch, promote from skid, or hold.
  // Payload is kept on flush/consume so id_pc etc. keep their last value.
  always_comb begin
    main_pc_d   = main_pc_q;
    main_inst_d = main_inst_q;
    main_sel_d  = main_sel_q;
    main_ill_d  = main_ill_q;
    if (load_main_from_in) begin
      main_pc_d   = bus.if_pc;
      main_inst_d = bus.if_inst;
      main_sel_d  = in_sel;
      main_ill_d  = in_ill;
    end else if (load_main_from_skid) begin
      main_pc_d   = skid_pc_q;
      main_inst_d = skid_inst_q;
      main_sel_d  = skid_sel_q;
      main_ill_d  = skid_ill_q;
    end
  end

  // Skid entry payload: only ever loaded from fetch
  always_comb begin
    skid_pc_d   = skid_pc_q;
    skid_inst_d = skid_inst_q;
    skid_sel_d  = skid_sel_q;
    skid_ill_d  = skid_ill_q;
    if (load_skid_from_in) begin
      skid_pc_d   = bus.if_pc;
      skid_inst_d = bus.if_inst;
      skid_sel_d  = in_sel;
      skid_ill_d  = in_ill;
    end
  end

  // Occupancy register; reset drops every buffered entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Main entry payload register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_pc_q   <= '0;
      main_inst_q <= NOP_INST;
      main_sel_q  <= IMM_I;
      main_ill_q  <= 1'b0;
    end else begin
      main_pc_q   <= main_pc_d;
      main_inst_q <= main_inst_d;
      main_sel_q  <= main_sel_d;
      main_ill_q  <= main_ill_d;
    end
  end

  // Skid entry payload register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_pc_q   <= '0;
      skid_inst_q <= NOP_INST;
      skid_sel_q  <= IMM_I;
      skid_ill_q  <= 1'b0;
    end else begin
      skid_pc_q   <= skid_pc_d;
      skid_inst_q <= skid_inst_d;
      skid_sel_q  <= skid_sel_d;
      skid_ill_q  <= skid_ill_d;
    end
  end

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Bench for if_id_skid_reg: a queue of in-flight instructions models the
// buffer (at most two entries, FIFO, cleared on flush/reset); a negedge
// process compares every output against it, and directed sections pin
// hand-computed literal values.
module tb_if_id_skid_reg;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  if_id_skid_if #(.DW(32)) bus ();

  if_id_skid_reg #(.DW(32), .NOP_INST(32'h0000_0013)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t mq[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected {illegal, imm_sel} straight from the opcode table
  function automatic logic [3:0] exp_dec(input logic [31:0] inst);
    logic [6:0] op;
    op = inst[6:0];
    case (op)
      7'h03, 7'h13, 7'h67: return 4'b0_000;
      7'h23:               return 4'b0_001;
      7'h63:               return 4'b0_010;
      7'h6F:               return 4'b0_011;
      7'h37, 7'h17:        return 4'b0_100;
      7'h73:               return 4'b0_101;
      7'h33:               return 4'b0_000;
      default:             return 4'b1_000;
    endcase
  endfunction

  // Model: a queue of at most two instructions
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n || flush) begin
        mq.delete();
      end else begin
        bit acc, con;
        acc = bus.if_valid && (mq.size() < 2);
        con = (mq.size() > 0) && bus.id_ready;
        if (con) void'(mq.pop_front());
        if (acc) mq.push_back('{bus.if_pc, bus.if_inst});
      end
    end
  end

  // Continuous compare, away from the active edge
  initial begin
    forever begin
      @(negedge clk);
      chk("id_valid", {31'b0, bus.id_valid}, {31'b0, mq.size() > 0});
      chk("if_ready", {31'b0, bus.if_ready}, {31'b0, mq.size() < 2});
      if (mq.size() > 0) begin
        logic [3:0] d;
        d = exp_dec(mq[0].inst);
        chk("id_pc",      bus.id_pc,   mq[0].pc);
        chk("id_inst",    bus.id_inst, mq[0].inst);
        chk("id_imm_sel", {29'b0, bus.id_imm_sel}, {29'b0, d[2:0]});
        chk("id_illegal", {31'b0, bus.id_illegal}, {31'b0, d[3]});
      end else begin
        chk("id_inst_nop", bus.id_inst, 32'h0000_0013);
      end
    end
  end

  // Watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic v, input logic [31:0] pc, input logic [31:0] inst);
    bus.if_valid = v;
    bus.if_pc    = pc;
    bus.if_inst  = inst;
  endtask

  logic [6:0]  ops [12] = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h6F,
                            7'h37, 7'h17, 7'h73, 7'h33, 7'h00, 7'h0B};
  logic [31:0] rnd;
  logic [31:0] pc_ctr;

  initial begin
    offer(1'b0, 32'h0, 32'h0);
    bus.id_ready = 1'b0;

    // Power-on reset
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    chk("rst_id_valid", {31'b0, bus.id_valid}, 32'd0);
    chk("rst_if_ready", {31'b0, bus.if_ready}, 32'd1);
    chk("rst_id_inst",  bus.id_inst, 32'h0000_0013);
    chk("rst_id_pc",    bus.id_pc,   32'h0);

    // Streaming with decode always ready: one-cycle latency, no bubbles
    bus.id_ready = 1'b1;
    offer(1'b1, 32'h0, 32'h0050_0093);
    tick();
    chk("s_pc0",  bus.id_pc, 32'h0);
    chk("s_sel0", {29'b0, bus.id_imm_sel}, 32'd0);
    offer(1'b1, 32'h4, 32'h0011_2023);
    tick();
    chk("s_pc4",  bus.id_pc, 32'h4);
    chk("s_sel4", {29'b0, bus.id_imm_sel}, 32'd1);
    offer(1'b1, 32'h8, 32'hFE00_0EE3);
    tick();
    chk("s_pc8",   bus.id_pc, 32'h8);
    chk("s_sel8",  {29'b0, bus.id_imm_sel}, 32'd2);
    chk("s_inst8", bus.id_inst, 32'hFE00_0EE3);
    offer(1'b0, 32'h0, 32'h0);
    tick();
    chk("s_idle_valid", {31'b0, bus.id_valid}, 32'd0);
    chk("s_idle_nop",   bus.id_inst, 32'h0000_0013);
    chk("s_hold_pc",    bus.id_pc, 32'h8);
    chk("s_hold_sel",   {29'b0, bus.id_imm_sel}, 32'd2);

    // Backpressure: two accepted, third held off, then drained in order
    bus.id_ready = 1'b0;
    offer(1'b1, 32'h100, 32'h0050_0093);
    tick();
    chk("bp_pcA", bus.id_pc, 32'h100);
    offer(1'b1, 32'h104, 32'h0011_2023);
    tick();
    chk("bp_full_ready", {31'b0, bus.if_ready}, 32'd0);
    offer(1'b1, 32'h108, 32'h0000_006F);
    tick();
    chk("bp_hold_pc",    bus.id_pc, 32'h100);
    chk("bp_hold_ready", {31'b0, bus.if_ready}, 32'd0);
    bus.id_ready = 1'b1;
    tick();
    chk("bp_pcB",  bus.id_pc, 32'h104);
    chk("bp_selB", {29'b0, bus.id_imm_sel}, 32'd1);
    tick();
    chk("bp_pcC",  bus.id_pc, 32'h108);
    chk("bp_selC", {29'b0, bus.id_imm_sel}, 32'd3);
    offer(1'b0, 32'h0, 32'h0);
    tick();
    chk("bp_drained", {31'b0, bus.id_valid}, 32'd0);

    // Flush while full, with an instruction offered in the flush cycle
    bus.id_ready = 1'b0;
    offer(1'b1, 32'h200, 32'h0050_0093);
    tick();
    offer(1'b1, 32'h204, 32'h0011_2023);
    tick();
    offer(1'b1, 32'h300, 32'h0000_006F);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    offer(1'b0, 32'h0, 32'h0);
    chk("fl_valid", {31'b0, bus.id_valid}, 32'd0);
    chk("fl_ready", {31'b0, bus.if_ready}, 32'd1);
    chk("fl_pc_kept", bus.id_pc, 32'h200);
    bus.id_ready = 1'b1;
    tick();
    chk("fl_no_ghost", {31'b0, bus.id_valid}, 32'd0);

    // Pre-decode of U/J/CSR/illegal opcodes
    offer(1'b1, 32'h400, 32'h0000_006F);
    tick();
    chk("pd_jal", {28'b0, bus.id_illegal, bus.id_imm_sel}, 32'h3);
    offer(1'b1, 32'h404, 32'h0000_12B7);
    tick();
    chk("pd_lui", {28'b0, bus.id_illegal, bus.id_imm_sel}, 32'h4);
    offer(1'b1, 32'h408, 32'h3000_2573);
    tick();
    chk("pd_csr", {28'b0, bus.id_illegal, bus.id_imm_sel}, 32'h5);
    offer(1'b1, 32'h40C, 32'h0000_0000);
    tick();
    chk("pd_ill", {28'b0, bus.id_illegal, bus.id_imm_sel}, 32'h8);
    offer(1'b0, 32'h0, 32'h0);
    tick();

    // Asynchronous reset in mid-cycle with an entry held
    bus.id_ready = 1'b0;
    offer(1'b1, 32'h500, 32'h0050_0093);
    tick();
    offer(1'b0, 32'h0, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", {31'b0, bus.id_valid}, 32'd0);
    chk("ar_nop",   bus.id_inst, 32'h0000_0013);
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    chk("ar_ready", {31'b0, bus.if_ready}, 32'd1);
    chk("ar_pc",    bus.id_pc, 32'h0);

    // Random valid/ready/flush against the queue model
    pc_ctr = 32'h1000;
    for (int i = 0; i < 10000; i++) begin
      rnd = $urandom();
      bus.if_valid = rnd[0] | rnd[1];
      bus.id_ready = rnd[2] | rnd[3];
      flush        = (rnd[7:4] == 4'h0);
      bus.if_pc    = pc_ctr;
      bus.if_inst  = {rnd[31:8], 1'b0, ops[$urandom_range(0, 11)]};
      pc_ctr       = pc_ctr + 32'd4;
      tick();
    end
    flush = 1'b0;
    offer(1'b0, 32'h0, 32'h0);
    bus.id_ready = 1'b1;
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
